// File: rtl/watch_time_counter.sv
// watch_time_counter
//
// Timekeeping core of the watch. A prescaler divides clk down to a once-per-
// second tick. Each tick advances binary seconds, minutes and hours, and all
// of their rollovers land on the same edge. In set mode the prescaler and the
// seconds are held at zero. Rising edges on the minute and hour buttons then
// adjust the minutes and hours independently, with no carry between them.
//
// Parameters:
//   CLK_DIV   clk cycles per one-second tick
//   HOUR_MOD  hour modulus (hours run 0..HOUR_MOD-1); must not exceed 100
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   run_en    1 = timekeeping runs, 0 = prescaler and counters hold
//   set_mode  1 = adjust mode (prescaler and seconds held at 0)
//   inc_min   minute-advance button level (debounced, synchronised)
//   inc_hour  hour-advance button level (debounced, synchronised)
//   sec       seconds 0-59, registered
//   min       minutes 0-59, registered
//   hour      hours 0..HOUR_MOD-1, registered
//   sec_tick  one-cycle pulse aligned with each new sec value
module watch_time_counter #(
    parameter int CLK_DIV  = 50000000,
    parameter int HOUR_MOD = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_en,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [6:0] sec,
    output logic [6:0] min,
    output logic [6:0] hour,
    output logic       sec_tick
);

    localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [6:0]    SEC_LAST   = 7'd59;
    localparam logic [6:0]    MIN_LAST   = 7'd59;
    localparam logic [6:0]    HOUR_LAST  = 7'(HOUR_MOD - 1);

    // set_mode takes priority over run_en
    typedef enum logic [1:0] {
        MODE_PAUSE,
        MODE_RUN,
        MODE_SET
    } mode_t;

    mode_t         mode;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic [6:0]    sec_next;
    logic [6:0]    min_next;
    logic [6:0]    hour_next;
    logic          tick;
    logic          prev_min;
    logic          prev_hour;
    logic          min_press;
    logic          hour_press;

    always_comb begin
        if (set_mode) begin
            mode = MODE_SET;
        end else if (run_en) begin
            mode = MODE_RUN;
        end else begin
            mode = MODE_PAUSE;
        end
    end

    // A press is the rising edge of the level input, so holding a button
    // counts once
    assign min_press  = inc_min  & ~prev_min;
    assign hour_press = inc_hour & ~prev_hour;

    always_comb begin
        presc_next = presc;
        sec_next   = sec;
        min_next   = min;
        hour_next  = hour;
        tick       = 1'b0;

        case (mode)
            MODE_RUN: begin
                if (presc == PRESC_LAST) begin
                    presc_next = '0;
                    tick       = 1'b1;
                    // Carries cascade combinationally so 23:59:59 -> 00:00:00
                    // happens on a single edge
                    if (sec == SEC_LAST) begin
                        sec_next = '0;
                        if (min == MIN_LAST) begin
                            min_next  = '0;
                            hour_next = (hour == HOUR_LAST) ? '0 : hour + 7'd1;
                        end else begin
                            min_next = min + 7'd1;
                        end
                    end else begin
                        sec_next = sec + 7'd1;
                    end
                end else begin
                    presc_next = presc + PW'(1);
                end
            end
            MODE_SET: begin
                presc_next = '0;
                sec_next   = '0;
                if (min_press) begin
                    min_next = (min == MIN_LAST) ? '0 : min + 7'd1;
                end
                if (hour_press) begin
                    hour_next = (hour == HOUR_LAST) ? '0 : hour + 7'd1;
                end
            end
            MODE_PAUSE: begin
                presc_next = presc;
            end
            default: begin
                presc_next = presc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            sec       <= '0;
            min       <= '0;
            hour      <= '0;
            sec_tick  <= 1'b0;
            prev_min  <= 1'b0;
            prev_hour <= 1'b0;
        end else begin
            presc     <= presc_next;
            sec       <= sec_next;
            min       <= min_next;
            hour      <= hour_next;
            sec_tick  <= tick;
            // Edge registers track in every mode so that a button already
            // held when set mode is entered does not count as a press
            prev_min  <= inc_min;
            prev_hour <= inc_hour;
        end
    end

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed bench for watch_time_counter with CLK_DIV=4 and HOUR_MOD=24.
// Expected time and tick values are pushed to a scoreboard queue while the
// stimulus is driven. They are popped and compared against the DUT outputs
// 1 time unit after the relevant clock edge.
module tb_watch_time_counter;

    logic       clk;
    logic       rst_n;
    logic       run_en;
    logic       set_mode;
    logic       inc_min;
    logic       inc_hour;
    logic [6:0] sec;
    logic [6:0] min;
    logic [6:0] hour;
    logic       sec_tick;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [6:0] s;
        logic [6:0] m;
        logic [6:0] h;
        logic       t;
    } exp_t;

    exp_t sb[$];

    watch_time_counter #(
        .CLK_DIV (4),
        .HOUR_MOD(24)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run_en  (run_en),
        .set_mode(set_mode),
        .inc_min (inc_min),
        .inc_hour(inc_hour),
        .sec     (sec),
        .min     (min),
        .hour    (hour),
        .sec_tick(sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input int s, input int m,
                            input int h, input int t);
        exp_t e;
        e.tag = tag;
        e.s   = 7'(s);
        e.m   = 7'(m);
        e.h   = 7'(h);
        e.t   = t[0];
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string fld,
                       input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
        end
    endtask

    task automatic chk();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            cmp(e.tag, "sec",  sec,  e.s);
            cmp(e.tag, "min",  min,  e.m);
            cmp(e.tag, "hour", hour, e.h);
            cmp(e.tag, "tick", {6'd0, sec_tick}, {6'd0, e.t});
        end
    endtask

    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) begin
            inc_min = 1'b1;
            step(1);
            inc_min = 1'b0;
            step(1);
        end
    endtask

    task automatic press_hour(input int n);
        for (int i = 0; i < n; i++) begin
            inc_hour = 1'b1;
            step(1);
            inc_hour = 1'b0;
            step(1);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        run_en   = 1'b1;
        set_mode = 1'b0;
        inc_min  = 1'b0;
        inc_hour = 1'b0;

        // Reset, then the first ticks
        step(3);
        push_exp("reset", 0, 0, 0, 0); chk();
        rst_n = 1'b1;
        push_exp("edge3", 0, 0, 0, 0); step(3); chk();
        push_exp("edge4", 1, 0, 0, 1); step(1); chk();
        push_exp("edge5", 1, 0, 0, 0); step(1); chk();
        push_exp("edge8", 2, 0, 0, 1); step(3); chk();
        push_exp("edge9", 2, 0, 0, 0); step(1); chk();

        // Pause after two prescaler counts keeps the partial second
        step(1);
        run_en = 1'b0;
        push_exp("pause", 2, 0, 0, 0); step(10); chk();
        run_en = 1'b1;
        push_exp("resume1", 2, 0, 0, 0); step(1); chk();
        push_exp("resume2", 3, 0, 0, 1); step(1); chk();

        // Button presses outside set mode do nothing
        run_en = 1'b0;
        inc_min = 1'b1; inc_hour = 1'b1;
        step(2);
        inc_min = 1'b0; inc_hour = 1'b0;
        push_exp("ignored", 3, 0, 0, 0); step(1); chk();

        // Set mode: seconds cleared, a held button counts once
        run_en = 1'b1;
        set_mode = 1'b1;
        push_exp("set_enter", 0, 0, 0, 0); step(1); chk();
        inc_min = 1'b1;
        push_exp("hold", 0, 1, 0, 0); step(10); chk();
        inc_min = 1'b0;
        step(1);
        push_exp("repress", 0, 2, 0, 0); press_min(1); chk();

        // Minute wrap does not carry into hour; both buttons together
        press_hour(5);
        push_exp("min59", 0, 59, 5, 0); press_min(57); chk();
        push_exp("min_wrap", 0, 0, 5, 0); press_min(1); chk();
        inc_min = 1'b1; inc_hour = 1'b1;
        step(1);
        inc_min = 1'b0; inc_hour = 1'b0;
        push_exp("both", 0, 1, 6, 0); step(1); chk();
        push_exp("hour23", 0, 1, 23, 0); press_hour(17); chk();
        push_exp("hour_wrap", 0, 1, 0, 0); press_hour(1); chk();
        press_hour(23);
        push_exp("set_2359", 0, 59, 23, 0); press_min(58); chk();

        // Leave set mode, run up to 23:59:59, then full rollover
        set_mode = 1'b0;
        push_exp("pre_tick", 0, 59, 23, 0); step(3); chk();
        push_exp("235959", 59, 59, 23, 1); step(4 * 59 - 3); chk();
        push_exp("midnight", 0, 0, 0, 1); step(4); chk();

        // Asynchronous reset at 12:34:56
        set_mode = 1'b1;
        press_hour(12);
        press_min(34);
        set_mode = 1'b0;
        push_exp("123456", 56, 34, 12, 1); step(4 * 56); chk();
        #1;
        rst_n = 1'b0;
        #2;
        push_exp("async_rst", 0, 0, 0, 0); chk();
        #1;
        rst_n = 1'b1;
        push_exp("post_rst3", 0, 0, 0, 0); step(3); chk();
        push_exp("post_rst4", 1, 0, 0, 1); step(1); chk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
